// File: rtl/ram_b_pkg.sv
// Shared RAM_B constants and controller state encoding, reused by RAM_B and bus glue.
package ram_b_pkg;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int RDATA_W = 48;
    localparam int DEPTH   = 128;
    localparam int LEN_W   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/ram_b_beat_ctr.sv
// Burst beat tracker: current beat address, remaining-beat count and RAM range check.
module ram_b_beat_ctr
    import ram_b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              count_zero,
    output logic              in_range
);

    logic [LEN_W-1:0] count;

    // Address wraps naturally at 2^ADDR_W.
    assign addr_next  = addr + ADDR_W'(1);
    assign count_zero = (count == '0);
    assign in_range   = addr_in_range(addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= load_addr;
            count <= load_len;
        end else if (step) begin
            addr  <= addr_next;
            count <= count - LEN_W'(1);
        end
    end

endmodule

// File: rtl/ram_b_master.sv
// Initiator-side controller for RAM_B: single writes and burst reads from a request
// channel, absorbing the RAM's one-cycle registered read latency.
module ram_b_master
    import ram_b_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [LEN_W-1:0]   req_len,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err,
    output logic               rsp_last,
    output logic               busy,
    output logic [ADDR_W-1:0]  mem_addra,
    output logic [DATA_W-1:0]  mem_dina,
    output logic               mem_wea,
    input  logic [RDATA_W-1:0] mem_douta
);

    // Both channels: a beat transfers on the clk edge where valid && ready are high;
    // the sender holds its payload stable until then and never withdraws valid.

    state_t state, state_d;

    logic              req_ready_d, rsp_valid_d, rsp_err_d, rsp_last_d, mem_wea_d;
    logic              is_write, is_write_d;
    logic [DATA_W-1:0] rsp_data_d, mem_dina_d;
    logic [ADDR_W-1:0] mem_addra_d;

    logic              ctr_load, ctr_step;
    logic [ADDR_W-1:0] beat_addr, beat_addr_next;
    logic              count_zero, beat_in_range;

    logic unused_douta_upper;
    assign unused_douta_upper = ^mem_douta[RDATA_W-1:DATA_W];

    assign busy = (state != IDLE);

    ram_b_beat_ctr u_beat_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .step       (ctr_step),
        .load_addr  (req_addr),
        .load_len   (req_len),
        .addr       (beat_addr),
        .addr_next  (beat_addr_next),
        .count_zero (count_zero),
        .in_range   (beat_in_range)
    );

    always_comb begin
        state_d     = state;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        rsp_last_d  = rsp_last;
        mem_addra_d = mem_addra;
        mem_dina_d  = mem_dina;
        mem_wea_d   = mem_wea;
        is_write_d  = is_write;
        ctr_load    = 1'b0;
        ctr_step    = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        is_write_d = 1'b1;
                        if (addr_in_range(req_addr)) begin
                            mem_addra_d = req_addr;
                            mem_dina_d  = req_wdata;
                            mem_wea_d   = 1'b1;
                            state_d     = WRITE;
                        end else begin
                            // Out-of-range write never touches the RAM port.
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                            rsp_last_d  = 1'b1;
                            state_d     = RESP;
                        end
                    end else begin
                        is_write_d  = 1'b0;
                        ctr_load    = 1'b1;
                        mem_addra_d = req_addr;
                        state_d     = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                mem_wea_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                rsp_last_d  = 1'b1;
                state_d     = RESP;
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_data_d  = beat_in_range ? mem_douta[DATA_W-1:0] : '0;
                rsp_err_d   = !beat_in_range;
                rsp_last_d  = count_zero;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last || is_write) begin
                        state_d = IDLE;
                    end else begin
                        ctr_step    = 1'b1;
                        mem_addra_d = beat_addr_next;
                        state_d     = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so it stays low through reset and rises on the first edge after.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
            mem_wea   <= 1'b0;
            is_write  <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            rsp_last  <= rsp_last_d;
            mem_addra <= mem_addra_d;
            mem_dina  <= mem_dina_d;
            mem_wea   <= mem_wea_d;
            is_write  <= is_write_d;
        end
    end

endmodule
